rgb_mem_access: RTL and testbench

RGB_MEM_ACCESS -- requirements
Module: rgb_mem_access

---
 rtl/rgb_mem_pkg.sv | 19 +
 rtl/rgb_mem_timeout.sv | 27 ++
 rtl/rgb_mem_access.sv | 123 ++++++++++++
 tb/tb_rgb_mem_access.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mem_pkg.sv
// Shared types and constants for the RGB framebuffer access block.
// Bounds checking on pixel addresses is enabled with RGB_MEM_BOUNDS_CHECK_EN.
package rgb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RGB_NONE = 2'b00;
  localparam logic [1:0] RGB_R    = 2'b01;
  localparam logic [1:0] RGB_G    = 2'b10;
  localparam logic [1:0] RGB_B    = 2'b11;

  localparam int unsigned PIXEL_COUNT = 76800;
  localparam int          TIMEOUT_DEF = 16;

endpackage

// File: rtl/rgb_mem_timeout.sv
// Cycle counter bounding how long a request may wait for an ack.
// expired is high in the cycle that would be the TIMEOUT-th unacked cycle.
module rgb_mem_timeout
  import rgb_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rgb_mem_access.sv
// Load/store path from the core to the RGB channel memories (IDLE/REQ/DONE).
// Define RGB_MEM_BOUNDS_CHECK_EN to abort accesses beyond the last pixel.
module rgb_mem_access
  import rgb_mem_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              ResultSrc,
  input  logic [1:0]        RGB,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              load_valid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  state_t     state;
  state_t     nxt;
  logic       req_present;
  logic       accept;
  logic       post_done;
  logic       is_rd;
  logic       abort;
  logic       oob;
  logic       expired;
  logic [7:0] rbyte;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign req_present  = (MemWrite | ResultSrc) & (RGB != RGB_NONE);

`ifdef RGB_MEM_BOUNDS_CHECK_EN
  assign oob = (32'(addr) >= PIXEL_COUNT);
`else
  assign oob = 1'b0;
`endif

  rgb_mem_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .enable ((state == REQ) && !mem_ack),
    .expired(expired)
  );

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        // the cycle right after DONE still sees the retiring instruction
        if (req_present && !post_done) begin
          accept = 1'b1;
          nxt    = oob ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_ack || expired) begin
          nxt = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      post_done <= 1'b0;
      is_rd     <= 1'b0;
      abort     <= 1'b0;
      rbyte     <= '0;
      mem_we    <= 1'b0;
      mem_bank  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nxt;
      post_done <= (state == DONE);
      if (accept) begin
        mem_we    <= MemWrite;
        is_rd     <= !MemWrite;
        mem_bank  <= RGB;
        mem_addr  <= addr;
        mem_wdata <= wdata[7:0];
        abort     <= oob;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          if (is_rd) rbyte <= mem_rdata;
        end else if (expired) begin
          abort <= 1'b1;
          if (is_rd) rbyte <= '0;
        end
      end
    end
  end

  assign stall = !rst &&
                 ((state == REQ) ||
                  ((state == IDLE) && req_present && !post_done));

  assign mem_req    = !rst && (state == REQ);
  assign load_valid = !rst && (state == DONE) && is_rd && !abort;
  assign err        = !rst && (state == DONE) && abort;
  assign rdata      = {24'd0, rbyte};

endmodule

// File: tb/tb_rgb_mem_access.sv
// Directed bench for rgb_mem_access: vector table plus corner sequences.
module tb_rgb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic        ResultSrc;
  logic [1:0]  RGB;
  logic [16:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        load_valid;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_bank;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  rgb_mem_access #(
    .ADDR_W (17),
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .ResultSrc (ResultSrc),
    .RGB       (RGB),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .load_valid(load_valid),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_bank  (mem_bank),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        mw;
    logic        rs;
    logic [1:0]  rgb;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mrd;
    int          ack_at;
    int          e_stalls;
    int          e_reqs;
    logic        e_we;
    logic [1:0]  e_bank;
    logic [16:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_lv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    RGB       = 2'b00;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int reqn;
    int stalls;
    bit done;
    reqn   = 0;
    stalls = 0;
    done   = 0;
    @(negedge clk);
    MemWrite  = v.mw;
    ResultSrc = v.rs;
    RGB       = v.rgb;
    addr      = v.addr;
    wdata     = v.wdata;
    mem_rdata = v.mrd;
    mem_ack   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        reqn++;
        chk($sformatf("v%0d we", idx), 32'(mem_we), 32'(v.e_we));
        chk($sformatf("v%0d bank", idx), 32'(mem_bank), 32'(v.e_bank));
        chk($sformatf("v%0d maddr", idx), 32'(mem_addr), 32'(v.e_addr));
        chk($sformatf("v%0d mwdata", idx), 32'(mem_wdata), 32'(v.e_wd));
        mem_ack = (reqn == v.ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (load_valid || err || (c > 0 && !stall)) begin
        done = 1;
        chk($sformatf("v%0d load_valid", idx), 32'(load_valid), 32'(v.e_lv));
        chk($sformatf("v%0d err", idx), 32'(err), 32'(v.e_err));
        chk($sformatf("v%0d rdata", idx), rdata, v.e_rdata);
        idle_inputs();
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d finished", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.e_stalls));
    chk($sformatf("v%0d req cycles", idx), 32'(reqn), 32'(v.e_reqs));
    idle_inputs();
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int reqn;
    bit seen;

    vecs[0] = '{1'b0, 1'b1, 2'b01, 17'd5, 32'h0, 8'hA7, 2,
                3, 2, 1'b0, 2'b01, 17'd5, 8'h00, 1'b1, 1'b0, 32'hA7};
    vecs[1] = '{1'b1, 1'b0, 2'b11, 17'd100, 32'h1234_56FF, 8'h55, 1,
                2, 1, 1'b1, 2'b11, 17'd100, 8'hFF, 1'b0, 1'b0, 32'hA7};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 17'd7, 32'h3C, 8'h99, 1,
                2, 1, 1'b1, 2'b10, 17'd7, 8'h3C, 1'b0, 1'b0, 32'hA7};
    vecs[3] = '{1'b0, 1'b1, 2'b10, 17'd76799, 32'h0, 8'h01, 3,
                4, 3, 1'b0, 2'b10, 17'd76799, 8'h00, 1'b1, 1'b0, 32'h01};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 17'd20, 32'hFF, 8'h00, 1,
                0, 0, 1'b0, 2'b00, 17'd0, 8'h00, 1'b0, 1'b0, 32'h01};
    vecs[5] = '{1'b0, 1'b0, 2'b11, 17'd20, 32'h0, 8'h00, 1,
                0, 0, 1'b0, 2'b00, 17'd0, 8'h00, 1'b0, 1'b0, 32'h01};
`ifdef RGB_MEM_BOUNDS_CHECK_EN
    vecs[6] = '{1'b0, 1'b1, 2'b01, 17'd76800, 32'h0, 8'h5A, 1,
                1, 0, 1'b0, 2'b00, 17'd0, 8'h00, 1'b0, 1'b1, 32'h01};
`else
    vecs[6] = '{1'b0, 1'b1, 2'b01, 17'd76800, 32'h0, 8'h5A, 1,
                2, 1, 1'b0, 2'b01, 17'd76800, 8'h00, 1'b1, 1'b0, 32'h5A};
`endif

    // reset with a request pending: nothing may stall or issue
    rst       = 1'b1;
    MemWrite  = 1'b1;
    ResultSrc = 1'b0;
    RGB       = 2'b01;
    addr      = 17'd3;
    wdata     = 32'h11;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst load_valid", 32'(load_valid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_bank", 32'(mem_bank), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    // stray ack in IDLE must do nothing
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    repeat (2) @(negedge clk);
    #1;
    chk("stray ack mem_req", 32'(mem_req), 32'd0);
    chk("stray ack load_valid", 32'(load_valid), 32'd0);
    chk("stray ack rdata", rdata, 32'd0);
    mem_ack = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // reset on the 3rd REQ cycle of a store
    @(negedge clk);
    MemWrite = 1'b1;
    RGB      = 2'b01;
    addr     = 17'd11;
    wdata    = 32'h22;
    reqn     = 0;
    seen     = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req) reqn++;
      if (reqn == 3) begin
        seen = 1;
        rst  = 1'b1;
        idle_inputs();
        #1;
        chk("rst midreq stall", 32'(stall), 32'd0);
        break;
      end
      @(negedge clk);
    end
    chk("rst midreq reached", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst after mem_req", 32'(mem_req), 32'd0);
    chk("rst after stall", 32'(stall), 32'd0);
    chk("rst after mem_we", 32'(mem_we), 32'd0);
    chk("rst after mem_addr", 32'(mem_addr), 32'd0);
    chk("rst after rdata", rdata, 32'd0);

    // read with no ack: abort after TIMEOUT REQ cycles
    @(negedge clk);
    ResultSrc = 1'b1;
    RGB       = 2'b11;
    addr      = 17'd9;
    mem_rdata = 8'h77;
    mem_ack   = 1'b0;
    rdata_pre: begin end
    reqn = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req) reqn++;
      if (err) begin
        seen = 1;
        chk("timeout load_valid", 32'(load_valid), 32'd0);
        chk("timeout rdata", rdata, 32'd0);
        chk("timeout stall", 32'(stall), 32'd0);
        idle_inputs();
        break;
      end
      @(negedge clk);
    end
    chk("timeout err seen", 32'(seen), 32'd1);
    chk("timeout req cycles", 32'(reqn), 32'd16);
    @(negedge clk);
    #1;
    chk("timeout err pulse", 32'(err), 32'd0);
    chk("timeout back idle", 32'(mem_req), 32'd0);

    // request held through DONE: ignored one cycle, then taken again
    @(negedge clk);
    ResultSrc = 1'b1;
    RGB       = 2'b01;
    addr      = 17'd3;
    mem_rdata = 8'h42;
    seen      = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      mem_ack = mem_req;
      if (load_valid) begin
        seen = 1;
        chk("hold rdata", rdata, 32'h42);
        break;
      end
      @(negedge clk);
    end
    chk("hold done seen", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    mem_ack = 1'b0;
    chk("hold blocked stall", 32'(stall), 32'd0);
    chk("hold blocked mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("hold retrigger stall", 32'(stall), 32'd1);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("hold dropped mem_req", 32'(mem_req), 32'd0);
    chk("hold dropped stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
